// File: rtl/pe_s10_accumulator.sv
// Dot-product accumulator behind a fixed-latency adder tree.
// Vector tags ride a LAT-deep delay line to line up with din, a two-state FSM
// sums (with saturation) the tree outputs of one product, and finished results
// land in a 2-entry first-word fall-through FIFO with registered outputs.
module pe_s10_accumulator #(
  parameter int unsigned DIN_W = 11,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LAT   = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic signed [DIN_W-1:0] din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] dout,
  output logic                    out_sat,
  output logic                    drop_err,
  output logic                    busy
);

  typedef enum logic {StIdle, StAccum} state_e;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  // Tag delay lines; bit LAT-1 is the tag aligned with the current din.
  logic [LAT-1:0] v_q, f_q, l_q;
  logic           v_dly, f_dly, l_dly;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W:0]   sum;
  logic                    ovf_hi, ovf_lo;
  logic signed [ACC_W-1:0] sum_sat;

  logic                    push;
  logic                    pop;

  // FIFO: head is the output register, tail is the second slot.
  logic [1:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0] head_q, head_d, tail_q, tail_d;
  logic                    head_sat_q, head_sat_d, tail_sat_q, tail_sat_d;
  logic                    valid_q, valid_d;
  logic                    drop_q, drop_d;

  assign v_dly = v_q[LAT-1];
  assign f_dly = f_q[LAT-1];
  assign l_dly = l_q[LAT-1];

  // Delay the vector tags by the adder-tree latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else begin
      v_q <= (v_q << 1) | LAT'(in_valid);
      f_q <= (f_q << 1) | LAT'(in_first);
      l_q <= (l_q << 1) | LAT'(in_last);
    end
  end

  // Saturating add in ACC_W+1 bits; overflow shows as disagreeing top bits.
  always_comb begin
    din_ext = ACC_W'(din);
    sum     = (ACC_W+1)'(acc_q) + (ACC_W+1)'(din_ext);
    ovf_hi  = ~sum[ACC_W] & sum[ACC_W-1];
    ovf_lo  = sum[ACC_W] & ~sum[ACC_W-1];
    if (ovf_hi) begin
      sum_sat = AccMax;
    end else if (ovf_lo) begin
      sum_sat = AccMin;
    end else begin
      sum_sat = sum[ACC_W-1:0];
    end
  end

  // Accumulator FSM next state; push carries the freshly computed acc/sat.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    push    = 1'b0;
    if (v_dly) begin
      unique case (state_q)
        StIdle: begin
          // A new product always starts here, first tag or not.
          acc_d   = din_ext;
          sat_d   = 1'b0;
          state_d = l_dly ? StIdle : StAccum;
          push    = l_dly;
        end
        StAccum: begin
          if (f_dly) begin
            acc_d = din_ext;
            sat_d = 1'b0;
          end else begin
            acc_d = sum_sat;
            sat_d = sat_q | ovf_hi | ovf_lo;
          end
          if (l_dly) begin
            state_d = StIdle;
            push    = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign pop = valid_q & out_ready;

  // FIFO next state: a push into a full FIFO only succeeds alongside a pop.
  always_comb begin
    cnt_d      = cnt_q;
    head_d     = head_q;
    head_sat_d = head_sat_q;
    tail_d     = tail_q;
    tail_sat_d = tail_sat_q;
    drop_d     = drop_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d     = acc_d;
          head_sat_d = sat_d;
          cnt_d      = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d     = acc_d;
          head_sat_d = sat_d;
        end else if (push) begin
          tail_d     = acc_d;
          tail_sat_d = sat_d;
          cnt_d      = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d     = tail_q;
          head_sat_d = tail_sat_q;
          if (push) begin
            tail_d     = acc_d;
            tail_sat_d = sat_d;
          end else begin
            cnt_d = 2'd1;
          end
        end else if (push) begin
          drop_d = 1'b1;
        end
      end
    endcase
    valid_d = (cnt_d != 2'd0);
  end

  // FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 2'd0;
      head_q     <= '0;
      head_sat_q <= 1'b0;
      tail_q     <= '0;
      tail_sat_q <= 1'b0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      head_sat_q <= head_sat_d;
      tail_q     <= tail_d;
      tail_sat_q <= tail_sat_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign dout      = head_q;
  assign out_sat   = head_sat_q;
  assign drop_err  = drop_q;
  assign busy      = (state_q == StAccum) | (|v_q);

endmodule
